// File: rtl/mac_mul_seq_ctrl_pkg.sv
// mac_mul_seq_ctrl_pkg: shared widths, cfg/state encodings and pass lookup for the MAC multiply sequencer
package mac_mul_seq_ctrl_pkg;
  localparam int MAC_MIN_WIDTH  = 8;
  localparam int MAC_CONF_WIDTH = 2;
  localparam int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH;
  localparam int ACC_WIDTH      = 8 * MAC_MIN_WIDTH;
  typedef enum logic [1:0] {CFG_SINGLE = 2'b00, CFG_DUAL = 2'b01, CFG_QUAD = 2'b10, CFG_ILLEGAL = 2'b11} cfg_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic logic [2:0] npass(input logic [MAC_CONF_WIDTH-1:0] cfg);
    return cfg == CFG_QUAD ? 3'd4 : cfg == CFG_DUAL ? 3'd2 : 3'd1;
  endfunction
  function automatic logic [4*MAC_MIN_WIDTH-1:0] lane_mask(input logic [MAC_CONF_WIDTH-1:0] cfg);
    return cfg == CFG_QUAD ? 32'hFFFF_FFFF : cfg == CFG_DUAL ? 32'h0000_FFFF : 32'h0000_00FF;
  endfunction
endpackage

// File: rtl/mac_mul_seq_ctrl_fsm.sv
// mac_mul_seq_fsm: IDLE/RUN/DONE control, pass counter and operand/result handshake
module mac_mul_seq_fsm
  import mac_mul_seq_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [MAC_CONF_WIDTH-1:0] in_cfg,
  input  logic                      out_ready,
  output logic                      in_ready,
  output logic                      accept,
  output logic                      run,
  output logic                      last,
  output logic [1:0]                k,
  output logic                      out_valid,
  output logic                      out_err
);
  state_e     state_q, state_d;
  logic [1:0] k_q, k_d, last_q, last_d;
  logic       err_q, err_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  // last_q holds the index of the final pass (npass-1)
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    last_d  = last_q;
    err_d   = err_q;
    if (state_q == IDLE && in_valid) begin
      state_d = in_cfg == CFG_ILLEGAL ? DONE : RUN;
      k_d     = '0;
      last_d  = 2'(npass(in_cfg) - 3'd1);
      err_d   = in_cfg == CFG_ILLEGAL;
    end else if (state_q == RUN) begin
      k_d     = k_q + 2'd1;
      state_d = k_q == last_q ? DONE : RUN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
      err_d   = 1'b0;
    end
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    accept    = in_ready && in_valid;
    run       = state_q == RUN;
    last      = run && k_q == last_q;
    k         = k_q;
    out_valid = state_q == DONE;
    out_err   = err_q;
  end
endmodule

// File: rtl/mac_mul_seq_ctrl.sv
// mac_mul_seq_ctrl: sequences an NxN multiply-accumulate over a multi-byte-A x one-byte-B multiply block
module mac_mul_seq_ctrl
  import mac_mul_seq_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4*MAC_MIN_WIDTH-1:0] in_a,
  input  logic [4*MAC_MIN_WIDTH-1:0] in_b,
  input  logic [MAC_CONF_WIDTH-1:0]  in_cfg,
  input  logic                       in_acc,
  output logic [MAC_MIN_WIDTH-1:0]   mul_a0,
  output logic [MAC_MIN_WIDTH-1:0]   mul_a1,
  output logic [MAC_MIN_WIDTH-1:0]   mul_a2,
  output logic [MAC_MIN_WIDTH-1:0]   mul_a3,
  output logic [MAC_MIN_WIDTH-1:0]   mul_b0,
  output logic [MAC_CONF_WIDTH-1:0]  mul_cfg,
  input  logic [MAC_INT_WIDTH-1:0]   mul_c,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       out_data,
  output logic                       out_err
);
  logic                       accept, run, last;
  logic [1:0]                 k;
  logic [4*MAC_MIN_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [MAC_CONF_WIDTH-1:0]  cfg_q, cfg_d;
  logic [ACC_WIDTH-1:0]       sum_q, sum_d, acc_q, acc_d, term, nxt;
  mac_mul_seq_fsm u_fsm (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_cfg(in_cfg), .out_ready(out_ready),
    .in_ready(in_ready), .accept(accept), .run(run), .last(last), .k(k),
    .out_valid(out_valid), .out_err(out_err)
  );
  // B is consumed by shifting, so mul_b0 is always its low byte straight from a flop
  always_comb begin
    a_d   = accept ? in_a & lane_mask(in_cfg) : a_q;
    b_d   = accept ? in_b : run ? b_q >> MAC_MIN_WIDTH : b_q;
    cfg_d = accept ? in_cfg : cfg_q;
    term  = ACC_WIDTH'(mul_c) << (MAC_MIN_WIDTH * k);
    nxt   = sum_q + term;
    sum_d = accept ? (in_acc ? acc_q : '0) : run ? nxt : sum_q;
    acc_d = last ? nxt : acc_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cfg_q <= '0;
      sum_q <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      cfg_q <= cfg_d;
      sum_q <= sum_d;
      acc_q <= acc_d;
    end
  assign {mul_a3, mul_a2, mul_a1, mul_a0} = a_q;
  assign mul_b0   = b_q[MAC_MIN_WIDTH-1:0];
  assign mul_cfg  = cfg_q;
  assign out_data = acc_q;
endmodule

// File: tb/tb_mac_mul_seq_ctrl.sv
// tb_mac_mul_seq_ctrl: directed ops against an arithmetic reference model with per-cycle output checks
module tb_mac_mul_seq_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_acc = 1'b0, out_valid, out_ready = 1'b0, out_err;
  logic [31:0] in_a = '0, in_b = '0;
  logic [1:0]  in_cfg = '0, mul_cfg;
  logic [7:0]  mul_a0, mul_a1, mul_a2, mul_a3, mul_b0;
  logic [39:0] mul_c;
  logic [63:0] out_data;
  int          total = 0, bad = 0;
  logic [7:0]  bseen [4];
  logic [23:0] ahi [4];

  mac_mul_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cfg(in_cfg), .in_acc(in_acc), .mul_a0(mul_a0), .mul_a1(mul_a1), .mul_a2(mul_a2), .mul_a3(mul_a3),
    .mul_b0(mul_b0), .mul_cfg(mul_cfg), .mul_c(mul_c), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  assign mul_c = 40'({mul_a3, mul_a2, mul_a1, mul_a0}) * 40'(mul_b0);

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: remaining RUN cycles, pending result, visible accumulator
  int          m_wait, m_pass, m_n;
  logic        m_valid, m_err;
  logic [1:0]  m_cfg;
  logic [31:0] m_a, m_b;
  logic [63:0] m_acc, m_res;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_wait = 0; m_pass = 0; m_valid = 0; m_err = 0; m_acc = '0; m_res = '0;
      m_a = '0; m_b = '0; m_cfg = '0;
    end else if (m_valid) begin
      if (out_ready) begin m_valid = 0; m_err = 0; end
    end else if (m_wait > 0) begin
      m_wait--; m_pass++;
      if (m_wait == 0) begin m_valid = 1; m_acc = m_res; end
    end else if (in_valid) begin
      if (in_cfg == 2'b11) begin m_valid = 1; m_err = 1; end
      else begin
        m_n    = 1 << in_cfg;
        m_a    = 32'((64'd1 << (8 * m_n)) - 1) & in_a;
        m_b    = 32'((64'd1 << (8 * m_n)) - 1) & in_b;
        m_cfg  = in_cfg;
        m_res  = (in_acc ? m_acc : 64'd0) + 64'(m_a) * 64'(m_b);
        m_wait = m_n;
        m_pass = 0;
      end
    end

  logic run_chk = 1'b0;
  always @(negedge clk)
    if (rst_n && run_chk) begin
      chk("in_ready", 64'(in_ready), 64'(!m_valid && m_wait == 0));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_err", 64'(out_err), 64'(m_err));
      chk("out_data", out_data, m_acc);
      if (m_wait > 0) begin
        chk("mul_b0", 64'(mul_b0), 64'(m_b >> (8 * m_pass)) & 64'hFF);
        chk("mul_a", 64'({mul_a3, mul_a2, mul_a1, mul_a0}), 64'(m_a));
        chk("mul_cfg", 64'(mul_cfg), 64'(m_cfg));
      end
    end

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c, input logic ac,
                    input logic [63:0] exp, input logic e, input int lat, input int hold);
    int n;
    n = 0;
    in_a = a; in_b = b; in_cfg = c; in_acc = ac; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      bseen[n % 4] = mul_b0;
      ahi[n % 4]   = {mul_a3, mul_a2, mul_a1};
      n++;
      @(negedge clk);
    end
    chk("latency", 64'(n + 1), 64'(lat));
    chk("result", out_data, exp);
    chk("result_err", 64'(out_err), 64'(e));
    if (hold > 0) begin
      in_valid = 1'b1; in_a = 32'h0000_0007; in_b = 32'h0000_0009; in_cfg = 2'b00; in_acc = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", out_data, exp);
        chk("hold_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("back_idle", 64'(in_ready), 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk("rst_mul", 64'({mul_a3, mul_a2, mul_a1, mul_a0, mul_b0, mul_cfg}), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_chk = 1'b1;
    chk("rst_ready", 64'(in_ready), 64'd1);
    op(32'h0F, 32'h11, 2'b00, 1'b0, 64'hFF, 1'b0, 2, 0);
    chk("single_ahi", 64'(ahi[0]), 64'd0);
    op(32'h1234, 32'h5678, 2'b01, 1'b0, 64'h0626_0060, 1'b0, 3, 0);
    chk("dual_b0_p0", 64'(bseen[0]), 64'h78);
    chk("dual_b0_p1", 64'(bseen[1]), 64'h56);
    op(32'h0102_0304, 32'h0506_0708, 2'b10, 1'b0, 64'h0005_1022_3C3D_3420, 1'b0, 5, 0);
    op(32'hFFFF_0003, 32'hEE00_0004, 2'b01, 1'b0, 64'h0C, 1'b0, 3, 0);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0, 5, 0);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 1'b1, 64'hFFFF_FFFC_0000_0002, 1'b0, 5, 0);
    op(32'h10, 32'h10, 2'b00, 1'b0, 64'h100, 1'b0, 2, 0);
    op(32'h02, 32'h03, 2'b00, 1'b1, 64'h106, 1'b0, 2, 0);
    op(32'h05, 32'h05, 2'b11, 1'b1, 64'h106, 1'b1, 1, 5);
    in_a = 32'h0102_0304; in_b = 32'h0506_0708; in_cfg = 2'b10; in_acc = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", out_data, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    op(32'h0002, 32'h0003, 2'b01, 1'b1, 64'h6, 1'b0, 3, 0);
    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
